// File: rtl/buf_executor_core_pkg.sv
// rtl/buf_executor_core_pkg.sv - shared opcodes, state enum and command word type
package buf_executor_core_pkg;

  localparam logic [7:0] OP_OUT_BASE    = 8'h80;
  localparam logic [7:0] OP_END         = 8'hBF;
  localparam logic [7:0] OP_WAIT_INT    = 8'h40;
  localparam logic [7:0] OP_WAIT_GLOBAL = 8'h41;
  localparam logic [7:0] OP_WAIT_LOCAL  = 8'h42;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_OUT_WAIT,
    ST_WAIT_COND
  } state_e;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [31:0] arg;
  } cmd_t;

  // OUT covers 0x80..0xBE; 0xBF shares the prefix but is END.
  function automatic logic is_out_op(input logic [7:0] op);
    return (op[7:6] == OP_OUT_BASE[7:6]) && (op != OP_END);
  endfunction

endpackage

// File: rtl/buf_executor_core.sv
// rtl/buf_executor_core.sv - command sequencer: fetches FIFO words, drives the
// output-register bus and waits on interrupt / FIFO-level conditions.
module buf_executor_core
  import buf_executor_core_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        fifo_empty,
  input  logic [39:0] fifo_data,
  output logic        fifo_read,
  input  logic [31:0] fifo_global_count,
  input  logic [31:0] fifo_local_count,
  input  logic        ext_out_reg_busy,
  input  logic [31:0] ext_pending_ints,
  output logic [5:0]  ext_out_reg_addr,
  output logic [31:0] ext_out_reg_data,
  output logic        ext_out_reg_stb,
  output logic [31:0] ext_clear_ints,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        aborted
);

  state_e      state_q, state_d;
  cmd_t        cmd_q, cmd_d;
  logic        fifo_read_q, fifo_read_d;
  logic        stb_q, stb_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        aborted_q, aborted_d;
  logic [5:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] clear_q, clear_d;
  logic [31:0] wait_mask;
  logic [31:0] int_hit;

  // A zero mask means "any interrupt".
  assign wait_mask = (cmd_q.arg == 32'd0) ? 32'hFFFF_FFFF : cmd_q.arg;
  assign int_hit   = ext_pending_ints & wait_mask;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    fifo_read_d = 1'b0;
    stb_d       = 1'b0;
    done_d      = 1'b0;
    clear_d     = 32'd0;
    addr_d      = addr_q;
    data_d      = data_q;
    error_d     = error_q;
    aborted_d   = aborted_q;

    if (abort) begin
      state_d   = ST_IDLE;
      aborted_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d   = ST_FETCH;
            error_d   = 1'b0;
            aborted_d = 1'b0;
          end
        end
        ST_FETCH: begin
          if (!fifo_empty) begin
            cmd_d       = fifo_data;
            fifo_read_d = 1'b1;
            state_d     = ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (is_out_op(cmd_q.opcode)) begin
            state_d = ST_OUT_WAIT;
          end else if (cmd_q.opcode == OP_END) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else if (cmd_q.opcode == OP_WAIT_INT ||
                       cmd_q.opcode == OP_WAIT_GLOBAL ||
                       cmd_q.opcode == OP_WAIT_LOCAL) begin
            state_d = ST_WAIT_COND;
          end else begin
            error_d = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_OUT_WAIT: begin
          if (!ext_out_reg_busy) begin
            stb_d   = 1'b1;
            addr_d  = cmd_q.opcode[5:0];
            data_d  = cmd_q.arg;
            state_d = ST_FETCH;
          end
        end
        ST_WAIT_COND: begin
          case (cmd_q.opcode)
            OP_WAIT_INT: begin
              if (int_hit != 32'd0) begin
                clear_d = int_hit;
                state_d = ST_FETCH;
              end
            end
            OP_WAIT_GLOBAL: if (fifo_global_count >= cmd_q.arg) state_d = ST_FETCH;
            OP_WAIT_LOCAL:  if (fifo_local_count >= cmd_q.arg) state_d = ST_FETCH;
            default: begin
              error_d = 1'b1;
              state_d = ST_IDLE;
            end
          endcase
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      fifo_read_q <= 1'b0;
      stb_q       <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      aborted_q   <= 1'b0;
      addr_q      <= 6'd0;
      data_q      <= 32'd0;
      clear_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      fifo_read_q <= fifo_read_d;
      stb_q       <= stb_d;
      done_q      <= done_d;
      error_q     <= error_d;
      aborted_q   <= aborted_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      clear_q     <= clear_d;
    end
  end

  assign fifo_read        = fifo_read_q;
  assign ext_out_reg_stb  = stb_q;
  assign ext_out_reg_addr = addr_q;
  assign ext_out_reg_data = data_q;
  assign ext_clear_ints   = clear_q;
  assign done             = done_q;
  assign error            = error_q;
  assign aborted          = aborted_q;
  assign busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_buf_executor_core.sv
// tb/tb_buf_executor_core.sv - directed bench with a FWFT FIFO model and pulse monitors
module tb_buf_executor_core;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        fifo_empty;
  logic [39:0] fifo_data;
  logic        fifo_read;
  logic [31:0] fifo_global_count;
  logic [31:0] fifo_local_count;
  logic        ext_out_reg_busy = 1'b0;
  logic [31:0] ext_pending_ints = 32'd0;
  logic [5:0]  ext_out_reg_addr;
  logic [31:0] ext_out_reg_data;
  logic        ext_out_reg_stb;
  logic [31:0] ext_clear_ints;
  logic        busy, done, error, aborted;

  buf_executor_core dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_read(fifo_read),
    .fifo_global_count(fifo_global_count), .fifo_local_count(fifo_local_count),
    .ext_out_reg_busy(ext_out_reg_busy), .ext_pending_ints(ext_pending_ints),
    .ext_out_reg_addr(ext_out_reg_addr), .ext_out_reg_data(ext_out_reg_data),
    .ext_out_reg_stb(ext_out_reg_stb), .ext_clear_ints(ext_clear_ints),
    .busy(busy), .done(done), .error(error), .aborted(aborted)
  );

  always #5 clk = ~clk;

  logic [39:0] mem [0:15];
  int wr_ptr = 0;
  int rd_ptr = 0;

  assign fifo_empty        = (wr_ptr == rd_ptr);
  assign fifo_data         = mem[rd_ptr % 16];
  assign fifo_local_count  = 32'(wr_ptr - rd_ptr);
  assign fifo_global_count = 32'(wr_ptr - rd_ptr);

  always @(posedge clk) begin
    if (fifo_read && (rd_ptr != wr_ptr)) rd_ptr <= rd_ptr + 1;
  end

  int          n_stb = 0, n_done = 0, n_read = 0, n_clear = 0;
  logic [5:0]  last_addr = 6'd0;
  logic [31:0] last_data = 32'd0;
  logic [31:0] last_clear = 32'd0;

  always @(negedge clk) begin
    if (ext_out_reg_stb) begin
      n_stb     <= n_stb + 1;
      last_addr <= ext_out_reg_addr;
      last_data <= ext_out_reg_data;
    end
    if (done) n_done <= n_done + 1;
    if (fifo_read) n_read <= n_read + 1;
    if (ext_clear_ints != 32'd0) begin
      n_clear    <= n_clear + 1;
      last_clear <= ext_clear_ints;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic push(input logic [39:0] w);
    mem[wr_ptr % 16] = w;
    wr_ptr++;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    for (int i = 0; i < max_cyc && busy; i++) @(negedge clk);
    #1;
    check(tag, busy, 1'b0);
  endtask

  int b_stb, b_done, b_read, b_clear;

  task automatic snap();
    b_stb = n_stb; b_done = n_done; b_read = n_read; b_clear = n_clear;
  endtask

  initial begin
    cycles(3);
    check("rst_busy", busy, 1'b0);
    check("rst_outs", {done, error, aborted, fifo_read, ext_out_reg_stb}, 5'd0);
    check("rst_bus", {ext_out_reg_addr, ext_out_reg_data, ext_clear_ints}, 70'd0);
    @(negedge clk);
    rst = 1'b1;

    // OUT then END
    snap();
    push(40'h80_00000000);
    push(40'hBF_00000000);
    pulse_start();
    wait_idle("t1_idle", 50);
    check("t1_stb_cnt", n_stb - b_stb, 1);
    check("t1_addr", last_addr, 6'd0);
    check("t1_data", last_data, 32'd0);
    check("t1_done_cnt", n_done - b_done, 1);
    check("t1_fifo_empty", fifo_empty, 1'b1);

    // start with empty FIFO starves in FETCH
    snap();
    pulse_start();
    cycles(5);
    check("t2_busy", busy, 1'b1);
    check("t2_no_read", n_read - b_read, 0);
    push(40'h80_00000000);
    cycles(10);
    check("t2_stb_cnt", n_stb - b_stb, 1);
    check("t2_busy_after", busy, 1'b1);
    check("t2_error", error, 1'b0);

    // OUT, WAIT_INT, OUT, END
    snap();
    push(40'h80_00000000);
    push(40'h40_00000000);
    push(40'h83_00000001);
    push(40'hBF_00000000);
    cycles(20);
    check("t3_stb_pre", n_stb - b_stb, 1);
    check("t3_stalled", busy, 1'b1);
    check("t3_no_clear", n_clear - b_clear, 0);
    check("t3_fifo_left", fifo_local_count, 32'd2);
    ext_pending_ints = 32'd1;
    wait_idle("t3_idle", 50);
    ext_pending_ints = 32'd0;
    check("t3_clear_cnt", n_clear - b_clear, 1);
    check("t3_clear_val", last_clear, 32'd1);
    check("t3_stb_cnt", n_stb - b_stb, 2);
    check("t3_addr", last_addr, 6'd3);
    check("t3_data", last_data, 32'd1);
    check("t3_done_cnt", n_done - b_done, 1);

    // OUT with register bus busy for 5 cycles
    snap();
    ext_out_reg_busy = 1'b1;
    push(40'h85_DEADBEEF);
    push(40'hBF_00000000);
    pulse_start();
    cycles(5);
    check("t4_no_stb", n_stb - b_stb, 0);
    ext_out_reg_busy = 1'b0;
    cycles(1);
    check("t4_stb_now", ext_out_reg_stb, 1'b1);
    cycles(1);
    check("t4_stb_gone", ext_out_reg_stb, 1'b0);
    wait_idle("t4_idle", 50);
    check("t4_stb_cnt", n_stb - b_stb, 1);
    check("t4_addr", last_addr, 6'd5);
    check("t4_data", last_data, 32'hDEADBEEF);

    // abort during WAIT_INT, then resume
    snap();
    push(40'h40_00000002);
    push(40'h81_00000007);
    push(40'hBF_00000000);
    pulse_start();
    cycles(10);
    check("t5_waiting", busy, 1'b1);
    check("t5_fifo_pre", fifo_local_count, 32'd2);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    check("t5_busy", busy, 1'b0);
    check("t5_aborted", aborted, 1'b1);
    check("t5_fifo_kept", fifo_local_count, 32'd2);
    check("t5_no_done", n_done - b_done, 0);
    pulse_start();
    #1;
    check("t5_aborted_clr", aborted, 1'b0);
    wait_idle("t5_idle", 50);
    check("t5_addr", last_addr, 6'd1);
    check("t5_data", last_data, 32'd7);
    check("t5_done_cnt", n_done - b_done, 1);

    // illegal opcode
    snap();
    push(40'h00_12345678);
    pulse_start();
    wait_idle("t6_idle", 50);
    check("t6_error", error, 1'b1);
    check("t6_no_stb", n_stb - b_stb, 0);
    check("t6_no_done", n_done - b_done, 0);
    check("t6_fifo_empty", fifo_empty, 1'b1);

    // simultaneous start and abort in IDLE: abort wins
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    #1;
    check("t7_busy", busy, 1'b0);
    check("t7_aborted", aborted, 1'b1);
    check("t7_error_kept", error, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/buf_executor_core.md
# buf_executor_core

Sequencer that fetches 40-bit command words from an external FIFO, executes them, and drives a peripheral output-register bus. It sits between the host-filled command buffer (the `fifo` block, instanced alongside) and the motion/IO register file. It runs from `start` until an END command, an error, or `abort`.

## Interface
- No parameters. Command width is fixed at 40 bits: opcode `[39:32]`, argument `[31:0]`.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle pulse; honoured only in IDLE.
- `abort`  in  1  one-cycle pulse; honoured in every state.
- `fifo_empty`  in  1  FIFO has no word.
- `fifo_data`  in  40  head word, first-word-fall-through; valid while `!fifo_empty`.
- `fifo_read`  out  1  pop strobe.
- `fifo_global_count`  in  32  words buffered system-wide.
- `fifo_local_count`  in  32  words in the attached FIFO.
- `ext_out_reg_busy`  in  1  register bus cannot accept a write.
- `ext_pending_ints`  in  32  level interrupt flags.
- `ext_out_reg_addr`  out  6  write address.
- `ext_out_reg_data`  out  32  write data.
- `ext_out_reg_stb`  out  1  write strobe, one cycle per write.
- `ext_clear_ints`  out  32  one-cycle clear pulse for consumed interrupts.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse on END.
- `error`  out  1  sticky; cleared by an accepted `start`.
- `aborted`  out  1  sticky; cleared by an accepted `start`.

## Operation
- States: IDLE, FETCH, EXEC, OUT_WAIT, WAIT_COND.
- IDLE, `start` → FETCH. Clear `error` and `aborted`.
- FETCH, `fifo_empty` → stay in FETCH. This is the normal starve case and is not an error.
- FETCH, not empty → latch `fifo_data` into the command register, pulse `fifo_read` for that one cycle, go to EXEC.
- Opcodes 0x80–0xBE (OUT): addr = opcode `[5:0]`, data = argument. Go to OUT_WAIT.
- OUT_WAIT: while `ext_out_reg_busy` is high, hold. When it is low, assert `ext_out_reg_stb` with addr/data for exactly one cycle, then go to FETCH.
- Opcode 0xBF (END): pulse `done`, go to IDLE.
- Opcode 0x40 (WAIT_INT): mask = argument, with 0 meaning 0xFFFF_FFFF. In WAIT_COND, wait until `ext_pending_ints & mask` is nonzero. Then pulse `ext_clear_ints` with that AND for one cycle and go to FETCH.
- Opcode 0x41 (WAIT_GLOBAL): wait in WAIT_COND until `fifo_global_count >= argument` (unsigned), then go to FETCH.
- Opcode 0x42 (WAIT_LOCAL): same comparison against `fifo_local_count`.
- Any other opcode: set `error`, go to IDLE. `done` does not pulse.
- `abort`: go to IDLE on the next edge and set `aborted`.
  - Has priority over every other transition.
  - No `fifo_read` and no `ext_out_reg_stb` in the same cycle.
  - Unread words stay in the FIFO.
- `start` while busy is ignored.
- Simultaneous `start` and `abort` in IDLE: abort wins and the block stays in IDLE.

## Timing
- Reset value of every output is 0. `ext_out_reg_*`, `ext_clear_ints`, `done` and `fifo_read` are registered.
- `start` → first `fifo_read` is at least 1 cycle later, provided the FIFO is non-empty.
- The FIFO is popped at most once per two cycles. There is always at least one EXEC cycle between pops, so `fifo_empty` can update.
- OUT with bus idle: FETCH → EXEC → strobe cycle, 3 cycles per command.
- WAIT_INT, WAIT_GLOBAL and WAIT_LOCAL evaluate the condition every cycle, with no timeout.
- `busy` drops in the cycle after END, error, or abort.
- Reset asserted mid-operation forces IDLE immediately. It clears all flags and pulses.

## Structure
- Shared package holds:
  - opcode constants OP_OUT_BASE = 0x80, OP_END = 0xBF, OP_WAIT_INT = 0x40, OP_WAIT_GLOBAL = 0x41, OP_WAIT_LOCAL = 0x42;
  - the state enum;
  - the 40-bit command word typedef.
- Single module. The FIFO is a separate block and is not instanced inside.

## Test plan
- Preload 0x80_00000000 and 0xBF_00000000, then pulse `start` → one strobe with addr 0, data 0. Then `done` pulses, `busy` falls, and the FIFO is empty.
- `start` with an empty FIFO → `busy`=1 and no `fifo_read`. Push 0x80_00000000 → exactly one strobe. `busy` stays 1.
- Push 0x80_00000000, 0x40_00000000, 0x83_00000001, 0xBF_00000000 → strobe to addr 0. The block then stalls until `ext_pending_ints` = 1. Then `ext_clear_ints` = 1 pulses, a strobe writes addr 3 with data 1, and `done` pulses.
- OUT with `ext_out_reg_busy` held high for 5 cycles → the strobe fires exactly once, in the first cycle after busy drops.
- `abort` during WAIT_INT → IDLE next cycle, `aborted`=1, remaining words still in the FIFO. A second `start` clears `aborted` and resumes from the next word.
- Opcode 0x00 → `error`=1, block goes to IDLE, no strobe, no `done`.
